hilo_muldiv_unit: RTL and testbench

Iterative multiply/divide engine that owns the HI and LO registers of the multicycle MIPS datapath. It consumes the microcoded EX/WB control for mult, div, madd, msub, mthi and mtlo, and operand values from the register file. It provides HI/LO to the mfhi/mflo write-back path. A start/busy/done handshake lets the microsequencer stall in its WB micro-state until the result is committed.

---
 rtl/hilo_pkg.sv | 22 ++
 rtl/muldiv_iter.sv | 69 ++++++
 rtl/hilo_muldiv_unit.sv | 132 +++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states
// and the default datapath width.
package hilo_pkg;

  localparam int unsigned HILO_WIDTH = 32;

  localparam logic [2:0] OP_MULT = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_MADD = 3'd2;
  localparam logic [2:0] OP_MSUB = 3'd3;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Shared unsigned shift/add-subtract datapath: shift-add multiply or restoring divide,
// one bit per step, with its own iteration counter.
module muldiv_iter
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = HILO_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             last,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] q
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_q, q_q, b_q, acc_d, q_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   x, y;
  logic [WIDTH+1:0] sum;

  // One adder serves both modes; divide subtracts via inverted operand plus carry-in.
  always_comb begin
    if (is_div) begin
      x = {acc_q, q_q[WIDTH-1]};
      y = ~{1'b0, b_q};
    end else begin
      x = {1'b0, acc_q};
      y = {1'b0, b_q} & {(WIDTH+1){q_q[0]}};
    end
    sum = {1'b0, x} + {1'b0, y} + {{(WIDTH+1){1'b0}}, is_div};
    if (is_div) begin
      // sum[WIDTH+1] is the no-borrow flag: keep the difference and shift in a 1.
      acc_d = sum[WIDTH+1] ? sum[WIDTH-1:0] : x[WIDTH-1:0];
      q_d   = {q_q[WIDTH-2:0], sum[WIDTH+1]};
    end else begin
      acc_d = sum[WIDTH:1];
      q_d   = {sum[0], q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      q_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else if (load) begin
      acc_q <= '0;
      q_q   <= a_in;
      b_q   <= b_in;
      cnt_q <= '0;
    end else if (step) begin
      acc_q <= acc_d;
      q_q   <= q_d;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign last = (cnt_q == CW'(WIDTH - 1));
  assign acc  = acc_q;
  assign q    = q_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner for the multicycle MIPS datapath: iterative signed mult/div plus mthi/mtlo.
// Define HILO_MADD_EN to enable MADD/MSUB accumulation; otherwise those ops are no-ops.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = HILO_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q;
  logic [2:0]         op_q;
  logic               neg_q, rem_neg_q;
  logic               busy_q, done_q, dbz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               accept, mul_go, div_go, iter_last;
  logic [WIDTH-1:0]   iter_a, iter_b, iter_acc, iter_q, quot, rem;
  logic [2*WIDTH-1:0] prod, sprod, fix_hilo;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  always_comb begin
    accept = start && !busy_q;
`ifdef HILO_MADD_EN
    mul_go = accept && (op == OP_MULT || op == OP_MADD || op == OP_MSUB);
`else
    mul_go = accept && (op == OP_MULT);
`endif
    div_go = accept && (op == OP_DIV) && (rt_val != '0);
    iter_a = div_go ? mag(rs_val) : mag(rt_val);
    iter_b = div_go ? mag(rt_val) : mag(rs_val);
  end

  muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (mul_go || div_go),
    .step   (state_q == MUL || state_q == DIV),
    .is_div (state_q == DIV),
    .a_in   (iter_a),
    .b_in   (iter_b),
    .last   (iter_last),
    .acc    (iter_acc),
    .q      (iter_q)
  );

  // Sign fix-up; remainder follows the dividend, quotient/product follow sign xor.
  always_comb begin
    prod  = {iter_acc, iter_q};
    sprod = neg_q ? -prod : prod;
    quot  = neg_q ? -iter_q : iter_q;
    rem   = rem_neg_q ? -iter_acc : iter_acc;
    if (op_q == OP_DIV) begin
      fix_hilo = {rem, quot};
    end else begin
      fix_hilo = sprod;
`ifdef HILO_MADD_EN
      if (op_q == OP_MADD) fix_hilo = {hi_q, lo_q} + sprod;
      else if (op_q == OP_MSUB) fix_hilo = {hi_q, lo_q} - sprod;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_MULT;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (accept) begin
            op_q      <= op;
            neg_q     <= rs_val[WIDTH-1] ^ rt_val[WIDTH-1];
            rem_neg_q <= rs_val[WIDTH-1];
            if (mul_go || div_go) begin
              state_q <= mul_go ? MUL : DIV;
              busy_q  <= 1'b1;
            end else begin
              // Single-cycle ops; a DIV landing here has a zero divisor.
              state_q <= DONE;
              done_q  <= 1'b1;
              dbz_q   <= (op == OP_DIV);
              if (op == OP_MTHI) hi_q <= rs_val;
              if (op == OP_MTLO) lo_q <= rs_val;
            end
          end
        end
        MUL, DIV: begin
          if (iter_last) state_q <= FIX;
        end
        FIX: begin
          {hi_q, lo_q} <= fix_hilo;
          state_q      <= DONE;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed vector bench for hilo_muldiv_unit: table of ops with hand-computed HI/LO,
// plus sequences for ignored start, mid-operation reset and back-to-back accept.
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  localparam int unsigned W  = 32;
  localparam int          LL = W + 1;

  logic         clk = 1'b0;
  logic         reset, start, busy, done, div_by_zero;
  logic [2:0]   op;
  logic [W-1:0] rs_val, rt_val, hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
    logic         edbz;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                     input int lt);
    vec_t v;
    v = '{o, a, b, eh, el, ed, lt};
    vecs.push_back(v);
  endtask

  // lat = rising edges after the accepting edge before done is seen (0 for single-cycle ops).
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bcnt, output bit stable);
    logic [W-1:0] hi0, lo0;
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    hi0 = hi; lo0 = lo;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = 3'd7; rs_val = $urandom; rt_val = $urandom;
    lat = 0; bcnt = 0; stable = 1'b1;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (hi !== hi0 || lo !== lo0) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, dcnt;
    bit stable;

    add(OP_MULT, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, LL);
    add(OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, LL);
    add(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, LL);
    add(OP_MTHI, 32'h0,        32'h0,        32'h00000000, 32'h80000000, 1'b0, 0);
    add(OP_MTLO, 32'hFFFFFFFF, 32'h0,        32'h00000000, 32'hFFFFFFFF, 1'b0, 0);
`ifdef HILO_MADD_EN
    add(OP_MADD, 32'd1,        32'd1,        32'h00000001, 32'h00000000, 1'b0, LL);
    add(OP_MSUB, 32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0, LL);
`else
    add(OP_MADD, 32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0, 0);
    add(OP_MSUB, 32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0, 0);
`endif
    add(OP_MTHI, 32'hA,        32'h0,        32'h0000000A, 32'hFFFFFFFF, 1'b0, 0);
    add(OP_MTLO, 32'hB,        32'h0,        32'h0000000A, 32'h0000000B, 1'b0, 0);
    add(OP_DIV,  32'd5,        32'd0,        32'h0000000A, 32'h0000000B, 1'b1, 0);
    add(OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, LL);
    add(OP_DIV,  32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0, LL);
    add(OP_MULT, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0, LL);
    add(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, LL);
    add(3'd6,    32'h1234,     32'h5678,     32'h00000000, 32'h00000001, 1'b0, 0);
    add(3'd7,    32'h1234,     32'h5678,     32'h00000000, 32'h00000001, 1'b0, 0);
    add(OP_DIV,  32'hFFFFFFF7, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h00000002, 1'b0, LL);

    reset = 1'b1; start = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset outputs", {busy, done, div_by_zero, hi, lo}, '0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, lat, bcnt, stable);
      chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d hi", i), hi, vecs[i].ehi);
      chk($sformatf("v%0d lo", i), lo, vecs[i].elo);
      chk($sformatf("v%0d div_by_zero", i), div_by_zero, vecs[i].edbz);
      chk($sformatf("v%0d busy in done cycle", i), busy, 1'b0);
      chk($sformatf("v%0d busy cycles", i), bcnt, (vecs[i].lat == 0) ? 0 : LL);
      if (vecs[i].lat != 0) chk($sformatf("v%0d hi/lo held", i), stable, 1'b1);
    end

    // Start while busy must be ignored; hi holds until the MULT commit.
    run_op(OP_MTHI, 32'h55, 32'h0, lat, bcnt, stable);
    chk("preset hi", hi, 32'h55);
    @(negedge clk);
    start = 1'b1; op = OP_MULT; rs_val = 32'd7; rt_val = 32'hFFFFFFFD;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; lat = 0; stable = 1'b1;
    while (!done && lat < 100) begin
      if (lat == 4) begin
        start = 1'b1; op = OP_MTHI; rs_val = 32'h1234;
      end else begin
        start = 1'b0;
      end
      if (hi !== 32'h55) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("ignored start latency", lat, LL);
    chk("ignored start hi held", stable, 1'b1);
    chk("ignored start result", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

    // Reset at T+10 aborts the operation and clears everything.
    @(negedge clk);
    start = 1'b1; op = OP_MULT; rs_val = 32'd3; rt_val = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort outputs", {busy, done, div_by_zero, hi, lo}, '0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("abort no late done", dcnt, 0);

    // Back-to-back: second start issued in the done cycle of the first.
    run_op(OP_MULT, 32'd3, 32'd5, lat, bcnt, stable);
    chk("b2b first latency", lat, LL);
    chk("b2b first result", {hi, lo}, 64'd15);
    start = 1'b1; op = OP_MULT; rs_val = 32'd2; rt_val = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; rs_val = 32'hDEAD; rt_val = 32'hBEEF; lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b second latency", lat, LL);
    chk("b2b second result", {hi, lo}, 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
